// File: rtl/gcd_requester.sv
// rtl/gcd_requester.sv - host-side request/response driver for the GCD control unit and datapath
// Rejects zero operands up front and aborts a run that never completes.
module gcd_requester #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_x,
  input  logic [WIDTH-1:0] req_y,
  output logic             go_o,
  output logic [WIDTH-1:0] x_o,
  output logic [WIDTH-1:0] y_o,
  input  logic             done_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_d,
  output logic             rsp_err,
  output logic             busy
);

  localparam int TW = $clog2(TIMEOUT + 1);
  // Timer counts completed WAIT cycles, so the last allowed cycle sees TIMEOUT-1.
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t        state;
  state_t        state_nx;
  logic [TW-1:0] timer;
  logic          accept;
  logic          zero_op;
  logic          timed_out;

  assign accept    = req_valid && req_ready;
  assign zero_op   = (req_x == '0) || (req_y == '0);
  assign timed_out = (timer == TLAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = zero_op ? S_RESP : S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (done_i || timed_out) state_nx = S_RESP;
      S_RESP:  if (rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Every output is a flop driven from the next state, so none sees an input combinationally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_ready <= 1'b0;
      busy      <= 1'b0;
      go_o      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_d     <= '0;
      x_o       <= '0;
      y_o       <= '0;
      timer     <= '0;
    end else begin
      req_ready <= (state_nx == S_IDLE);
      busy      <= (state_nx != S_IDLE);
      go_o      <= (state_nx == S_ISSUE);
      rsp_valid <= (state_nx == S_RESP);
      if (state == S_IDLE && accept) begin
        x_o <= req_x;
        y_o <= req_y;
        if (zero_op) begin
          rsp_d   <= '0;
          rsp_err <= 1'b1;
        end
      end
      if (state == S_ISSUE) begin
        timer <= '0;
      end
      if (state == S_WAIT) begin
        timer <= timer + 1'b1;
        if (done_i) begin
          rsp_d   <= d_i;
          rsp_err <= 1'b0;
        end else if (timed_out) begin
          rsp_d   <= '0;
          rsp_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gcd_requester.sv
// tb/tb_gcd_requester.sv - directed self-checking bench for gcd_requester
// The bench plays the GCD unit: it drives done_i/d_i by hand at chosen WAIT cycles.
module tb_gcd_requester;

  logic       clk;
  logic       reset_n;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_x;
  logic [7:0] req_y;
  logic       go_o;
  logic [7:0] x_o;
  logic [7:0] y_o;
  logic       done_i;
  logic [7:0] d_i;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_d;
  logic       rsp_err;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  int go_cnt = 0;
  int go_base;

  gcd_requester #(.WIDTH(8), .TIMEOUT(15)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
    .go_o(go_o), .x_o(x_o), .y_o(y_o), .done_i(done_i), .d_i(d_i),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_d(rsp_d), .rsp_err(rsp_err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (go_o) go_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] x, input logic [7:0] y);
    req_valid = 1'b1;
    req_x = x;
    req_y = y;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_x = '0; req_y = '0;
    done_i = 1'b0; d_i = '0; rsp_ready = 1'b0;
    #12;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_go", 32'(go_o), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_rsp_d", 32'(rsp_d), 0);
    chk("rst_x", 32'(x_o), 0);
    @(negedge clk) reset_n = 1'b1;
    tick();
    chk("idle_req_ready", 32'(req_ready), 1);

    // 1: (12,8), done five cycles after go
    go_base = go_cnt;
    send(8'd12, 8'd8);
    chk("t1_go", 32'(go_o), 1);
    chk("t1_x", 32'(x_o), 12);
    chk("t1_y", 32'(y_o), 8);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_req_ready", 32'(req_ready), 0);
    tick();
    chk("t1_go_single", 32'(go_o), 0);
    repeat (4) tick();
    chk("t1_x_hold", 32'(x_o), 12);
    chk("t1_no_rsp_yet", 32'(rsp_valid), 0);
    done_i = 1'b1; d_i = 8'd4;
    tick();
    done_i = 1'b0; d_i = 8'd0;
    chk("t1_rsp_valid", 32'(rsp_valid), 1);
    chk("t1_rsp_d", 32'(rsp_d), 4);
    chk("t1_rsp_err", 32'(rsp_err), 0);
    chk("t1_go_pulses", 32'(go_cnt - go_base), 1);
    handshake();
    chk("t1_done_idle", 32'(rsp_valid), 0);
    chk("t1_busy_idle", 32'(busy), 0);

    // 2: zero operand, GCD unit never started; request offered in handshake cycle is refused
    go_base = go_cnt;
    send(8'd0, 8'd9);
    chk("t2_rsp_valid", 32'(rsp_valid), 1);
    chk("t2_rsp_err", 32'(rsp_err), 1);
    chk("t2_rsp_d", 32'(rsp_d), 0);
    chk("t2_go", 32'(go_o), 0);
    req_valid = 1'b1; req_x = 8'd5; req_y = 8'd5;
    handshake();
    req_valid = 1'b0;
    chk("t2_go_pulses", 32'(go_cnt - go_base), 0);
    chk("t2_rsp_clear", 32'(rsp_valid), 0);
    chk("t2_no_accept_x", 32'(x_o), 0);
    chk("t2_busy", 32'(busy), 0);

    // 3: no completion -> timeout after exactly 15 WAIT cycles
    send(8'd3, 8'd5);
    repeat (15) tick();
    chk("t3_wait15_no_rsp", 32'(rsp_valid), 0);
    tick();
    chk("t3_rsp_valid", 32'(rsp_valid), 1);
    chk("t3_rsp_err", 32'(rsp_err), 1);
    chk("t3_rsp_d", 32'(rsp_d), 0);
    handshake();

    // 4: response held under backpressure; stray done_i ignored
    send(8'd21, 8'd14);
    tick();
    done_i = 1'b1; d_i = 8'd7;
    tick();
    done_i = 1'b0; d_i = 8'd0;
    chk("t4_rsp_err", 32'(rsp_err), 0);
    req_valid = 1'b1; req_x = 8'd1; req_y = 8'd1;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin done_i = 1'b1; d_i = 8'h55; end
      else begin done_i = 1'b0; d_i = 8'h00; end
      tick();
      chk("t4_hold_valid", 32'(rsp_valid), 1);
      chk("t4_hold_d", 32'(rsp_d), 7);
      chk("t4_hold_req_ready", 32'(req_ready), 0);
    end
    done_i = 1'b0;
    req_valid = 1'b0;
    handshake();
    chk("t4_x_unchanged", 32'(x_o), 21);

    // 5: asynchronous reset mid-WAIT abandons the transaction
    send(8'd40, 8'd30);
    repeat (3) tick();
    #2 reset_n = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_go", 32'(go_o), 0);
    chk("t5_rsp_valid", 32'(rsp_valid), 0);
    chk("t5_x", 32'(x_o), 0);
    chk("t5_y", 32'(y_o), 0);
    chk("t5_req_ready", 32'(req_ready), 0);
    @(negedge clk) reset_n = 1'b1;
    tick();
    chk("t5_ready_after", 32'(req_ready), 1);
    chk("t5_no_rsp", 32'(rsp_valid), 0);
    send(8'd9, 8'd6);
    tick();
    done_i = 1'b1; d_i = 8'd3;
    tick();
    done_i = 1'b0; d_i = 8'd0;
    chk("t5_rsp_valid", 32'(rsp_valid), 1);
    chk("t5_rsp_d", 32'(rsp_d), 3);
    handshake();

    // 6: done_i in IDLE ignored; done_i coinciding with the timeout cycle wins
    done_i = 1'b1; d_i = 8'hAA;
    tick();
    done_i = 1'b0; d_i = 8'd0;
    chk("t6_idle_busy", 32'(busy), 0);
    chk("t6_idle_rsp", 32'(rsp_valid), 0);
    chk("t6_idle_d", 32'(rsp_d), 3);
    chk("t6_idle_ready", 32'(req_ready), 1);
    send(8'd50, 8'd20);
    repeat (15) tick();
    chk("t6_wait15_no_rsp", 32'(rsp_valid), 0);
    done_i = 1'b1; d_i = 8'd10;
    tick();
    done_i = 1'b0; d_i = 8'd0;
    chk("t6_rsp_valid", 32'(rsp_valid), 1);
    chk("t6_rsp_err", 32'(rsp_err), 0);
    chk("t6_rsp_d", 32'(rsp_d), 10);
    handshake();
    chk("t6_end_idle", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
